// File: rtl/ifr_pkg.sv
// Shared defaults and the buffered fetch-entry layout for the instruction-fetch-ready queue.
package ifr_pkg;

  localparam int unsigned XLEN_DEF         = 64;
  localparam int unsigned ILEN_DEF         = 32;
  localparam logic [31:0] BUBBLE_INSTR_DEF = 32'h0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } ifr_entry_t;

endpackage

// File: rtl/ifr_fifo.sv
// Register-based FIFO of fetch entries; synchronous flush empties it in one cycle.
module ifr_fifo
  import ifr_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = ifr_entry_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  entry_t                       din,
  output entry_t                       dout,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign dout      = mem[rd_ptr];
  assign occupancy = count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ifr_queue.sv
// Instruction-fetch-ready stage: channel mux, accept handshake, FIFO buffering and a
// registered output slot feeding decode.
module pipeline_ifr_queue
  import ifr_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter int unsigned     ILEN         = ILEN_DEF,
  parameter int unsigned     N_CH         = 2,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [ILEN-1:0] BUBBLE_INSTR = ILEN'(BUBBLE_INSTR_DEF),
  localparam int unsigned    SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned    OCC_W        = $clog2(DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       ifp_valid,
  input  logic [XLEN-1:0]            pc_IFP,
  input  logic [SEL_W-1:0]           if_channel_sel,
  input  logic [N_CH-1:0][ILEN-1:0]  ch_dout,
  input  logic [N_CH-1:0]            ch_data_ready,
  output logic                       ifp_ready,
  output logic [XLEN-1:0]            pc_IFR,
  output logic [ILEN-1:0]            Instruction,
  output logic                       ifr_valid,
  output logic [OCC_W-1:0]           occupancy,
  output logic                       sel_err
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  int unsigned      sel_idx;
  logic             in_range;
  logic             src_ready;
  logic [ILEN-1:0]  src_instr;
  logic             acc;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  entry_t           cap_entry;
  entry_t           head_entry;

  // Loop-compare mux keeps an out-of-range select from indexing past the channel array.
  always_comb begin
    sel_idx   = 32'(if_channel_sel);
    in_range  = (sel_idx < N_CH);
    src_ready = 1'b0;
    src_instr = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (sel_idx == c) begin
        src_ready = ch_data_ready[c];
        src_instr = ch_dout[c];
      end
    end
  end

  assign acc       = ifp_valid & in_range & src_ready & ~fifo_full & ~flush;
  assign ifp_ready = acc;
  assign cap_entry = '{pc: pc_IFP, instr: src_instr};

  // Bypass into the slot only when the FIFO is empty and the slot advances.
  assign pop  = ~stall & ~fifo_empty & ~flush;
  assign push = acc & ~(~stall & fifo_empty);

  ifr_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .din       (cap_entry),
    .dout      (head_entry),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_IFR      <= '0;
      Instruction <= BUBBLE_INSTR;
      ifr_valid   <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      sel_err <= ifp_valid & ~in_range;
      if (flush) begin
        pc_IFR      <= '0;
        Instruction <= BUBBLE_INSTR;
        ifr_valid   <= 1'b0;
      end else if (~stall) begin
        if (~fifo_empty) begin
          pc_IFR      <= head_entry.pc;
          Instruction <= head_entry.instr;
          ifr_valid   <= 1'b1;
        end else if (acc) begin
          pc_IFR      <= cap_entry.pc;
          Instruction <= cap_entry.instr;
          ifr_valid   <= 1'b1;
        end else begin
          pc_IFR      <= '0;
          Instruction <= BUBBLE_INSTR;
          ifr_valid   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ifr_queue.sv
// Directed plus randomized bench for pipeline_ifr_queue, checked against a queue-based model.
module tb_pipeline_ifr_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       stall;
  logic                       flush;
  logic                       ifp_valid;
  logic [XLEN-1:0]            pc_IFP;
  logic [1:0]                 if_channel_sel;
  logic [N_CH-1:0][ILEN-1:0]  ch_dout;
  logic [N_CH-1:0]            ch_data_ready;
  logic                       ifp_ready;
  logic [XLEN-1:0]            pc_IFR;
  logic [ILEN-1:0]            Instruction;
  logic                       ifr_valid;
  logic [2:0]                 occupancy;
  logic                       sel_err;

  pipeline_ifr_queue #(
    .XLEN         (XLEN),
    .ILEN         (ILEN),
    .N_CH         (N_CH),
    .DEPTH        (DEPTH),
    .BUBBLE_INSTR (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ifp_valid      (ifp_valid),
    .pc_IFP         (pc_IFP),
    .if_channel_sel (if_channel_sel),
    .ch_dout        (ch_dout),
    .ch_data_ready  (ch_data_ready),
    .ifp_ready      (ifp_ready),
    .pc_IFR         (pc_IFR),
    .Instruction    (Instruction),
    .ifr_valid      (ifr_valid),
    .occupancy      (occupancy),
    .sel_err        (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  logic [31:0] m_ins;
  logic        m_v;
  logic        m_err;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc  = '0;
    m_ins = '0;
    m_v   = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ":pc_IFR"},      pc_IFR,      m_pc);
    chk({tag, ":Instruction"}, Instruction, {32'h0, m_ins});
    chk({tag, ":ifr_valid"},   ifr_valid,   m_v);
    chk({tag, ":occupancy"},   occupancy,   64'(q.size()));
    chk({tag, ":sel_err"},     sel_err,     m_err);
  endtask

  // One clock: check the combinational handshake, clock, advance the model, check outputs.
  task automatic step(input string tag);
    int unsigned s;
    logic        ok;
    ent_t        e;
    #1;
    s  = 32'(if_channel_sel);
    ok = ifp_valid && (s < N_CH) && ch_data_ready[s[1:0]] && (q.size() < DEPTH) && !flush;
    chk({tag, ":ifp_ready"}, ifp_ready, ok);
    e.pc  = pc_IFP;
    e.ins = (s < N_CH) ? ch_dout[s[1:0]] : 32'h0;
    @(posedge clk);
    m_err = ifp_valid && (s >= N_CH);
    if (flush) begin
      q.delete();
      m_v = 1'b0; m_pc = '0; m_ins = '0;
    end else if (!stall) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        m_v = 1'b1; m_pc = e.pc; m_ins = e.ins;
        if (ok) q.push_back('{pc: pc_IFP, ins: ch_dout[s[1:0]]});
      end else if (ok) begin
        m_v = 1'b1; m_pc = e.pc; m_ins = e.ins;
      end else begin
        m_v = 1'b0; m_pc = '0; m_ins = '0;
      end
    end else if (ok) begin
      q.push_back(e);
    end
    #1;
    chk_outputs(tag);
  endtask

  task automatic rom_req(input logic [63:0] pc);
    ifp_valid      = 1'b1;
    if_channel_sel = 2'd0;
    pc_IFP         = pc;
    ch_dout[0]     = 32'h0000_0013 ^ pc[31:0];
  endtask

  initial begin
    logic pending;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ifp_valid = 1'b0;
    pc_IFP = '0; if_channel_sel = '0; ch_dout = '0; ch_data_ready = 3'b001;
    model_reset();
    @(posedge clk); #1;
    chk_outputs("reset");
    chk("reset:ifp_ready", ifp_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Bypass from ROM with empty FIFO
    ifp_valid = 1'b1; if_channel_sel = 2'd0; pc_IFP = 64'h1000; ch_dout[0] = 32'h0000_0013;
    step("bypass");
    chk("bypass:pc", pc_IFR, 64'h1000);
    chk("bypass:instr", Instruction, 32'h13);
    chk("bypass:occ", occupancy, 3'd0);

    // DRAM wait: channel 1 not ready for three cycles
    if_channel_sel = 2'd1; pc_IFP = 64'h1004; ch_dout[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      ch_data_ready = 3'b001;
      step("dram_wait");
      chk("dram_wait:valid", ifr_valid, 1'b0);
    end
    ch_data_ready = 3'b011; ch_dout[1] = 32'h00A0_0093;
    step("dram_ready");
    chk("dram_ready:instr", Instruction, 32'h00A0_0093);
    ifp_valid = 1'b0;
    step("idle");

    // Stall fill: five back-to-back ROM requests, the fifth is refused
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rom_req(64'h2000 + 64'(4 * i));
      step("stall_fill");
    end
    chk("stall_fill:occ", occupancy, 3'd4);
    chk("stall_fill:ready5", ifp_ready, 1'b0);
    ifp_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("drain");
      if (i < 4) chk("drain:order", pc_IFR, 64'h2000 + 64'(4 * i));
    end

    // Simultaneous push/pop across pointer wrap
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin rom_req(64'h3000 + 64'(4 * i)); step("pp_fill"); end
    stall = 1'b0;
    for (int i = 2; i < 12; i++) begin
      rom_req(64'h3000 + 64'(4 * i));
      step("pushpop");
      chk("pushpop:occ", occupancy, 3'd2);
      chk("pushpop:order", pc_IFR, 64'h3000 + 64'(4 * (i - 2)));
    end
    ifp_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("pp_drain");

    // Flush beats stall and refuses the same-cycle request
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin rom_req(64'h4000 + 64'(4 * i)); step("fl_fill"); end
    chk("fl_fill:occ", occupancy, 3'd3);
    flush = 1'b1; rom_req(64'h400C);
    step("flush");
    chk("flush:occ", occupancy, 3'd0);
    chk("flush:instr", Instruction, 32'h0);
    flush = 1'b0; stall = 1'b0; ifp_valid = 1'b0;
    step("post_flush");

    // Out-of-range select
    ifp_valid = 1'b1; if_channel_sel = 2'd3; pc_IFP = 64'h5000; ch_data_ready = 3'b111;
    step("sel_err");
    chk("sel_err:pulse", sel_err, 1'b1);
    ifp_valid = 1'b0; if_channel_sel = 2'd0;
    step("sel_err_clr");
    chk("sel_err:clear", sel_err, 1'b0);

    // Asynchronous reset mid-fill
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin rom_req(64'h6000 + 64'(4 * i)); step("rst_fill"); end
    ifp_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_outputs("midreset");
    #1 reset = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    chk_outputs("after_reset");

    // Randomized traffic obeying the hold-until-ready protocol
    pending = 1'b0;
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 19) == 0);
      ch_data_ready = {1'($urandom), 1'($urandom), 1'b1};
      ch_dout = {$urandom, $urandom, $urandom};
      if (!pending) begin
        ifp_valid      = ($urandom_range(0, 3) != 0);
        if_channel_sel = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        pc_IFP         = {32'h0, $urandom} & ~64'h3;
      end
      #1;
      pending = ifp_valid && !ifp_ready && !flush && (if_channel_sel != 2'd3);
      #0 step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
